// File: rtl/instr_queue_pkg.sv
// Shared front-end constants and fetch-queue FSM state type.
package instr_queue_pkg;

  localparam int unsigned PcLength    = 32;
  localparam int unsigned InstrLength = 32;
  localparam logic [31:0] Zero        = '0;

  typedef enum logic [1:0] {
    IQ_IDLE = 2'd0,
    IQ_WAIT = 2'd1,
    IQ_DROP = 2'd2
  } iq_state_e;

endpackage

// File: rtl/iq_fifo.sv
// Circular buffer of {pc, instr} entries with push, pop, flush and show-ahead head read.
module iq_fifo
  import instr_queue_pkg::*;
#(
  parameter int unsigned DepthLog = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [PcLength-1:0]    i_pc,
  input  logic [InstrLength-1:0] i_instr,
  output logic [PcLength-1:0]    o_pc,
  output logic [InstrLength-1:0] o_instr,
  output logic [DepthLog:0]      o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int unsigned Depth = 1 << DepthLog;

  logic [PcLength-1:0]    r_pc_mem    [Depth];
  logic [InstrLength-1:0] r_instr_mem [Depth];
  logic [DepthLog-1:0]    r_head;
  logic [DepthLog-1:0]    r_tail;
  logic [DepthLog:0]      r_count;
  logic                   w_push;
  logic                   w_pop;

  assign o_full  = (r_count == (DepthLog+1)'(Depth));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_pc    = r_pc_mem[r_head];
  assign o_instr = r_instr_mem[r_head];

  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop  = i_pop && !o_empty && !i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + DepthLog'(1);
      if (w_pop)  r_head <= r_head + DepthLog'(1);
      if (w_push && !w_pop)      r_count <= r_count + (DepthLog+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (DepthLog+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]    <= i_pc;
      r_instr_mem[r_tail] <= i_instr;
    end
  end

endmodule

// File: rtl/instr_queue.sv
// Instruction fetch queue: sequential fetch FSM, redirect handling and decoder head port.
// Optional same-cycle empty-queue bypass enabled by INSTR_QUEUE_BYPASS_EN.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int unsigned QueueDepthLog = 4,
  parameter logic [31:0] ResetPc       = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pop_from_dc,
  input  logic        jump_from_rob,
  input  logic [31:0] target_pc_from_rob,
  input  logic [31:0] instr_from_mem,
  input  logic        valid_from_mem,
  output logic        req_to_mem,
  output logic [31:0] addr_to_mem,
  output logic        is_empty_to_dc,
  output logic [31:0] pc_to_dc,
  output logic [31:0] instr_to_dc
);

  iq_state_e              r_state;
  iq_state_e              w_state_nxt;
  logic [PcLength-1:0]    r_fetch_pc;
  logic [PcLength-1:0]    w_fetch_pc_nxt;
  logic [PcLength-1:0]    r_addr;
  logic                   w_latch_addr;
  logic                   w_push;
  logic                   w_bypass;
  logic [PcLength-1:0]    w_head_pc;
  logic [InstrLength-1:0] w_head_instr;
  logic [QueueDepthLog:0] w_count;
  logic                   w_full;
  logic                   w_empty;

`ifdef INSTR_QUEUE_BYPASS_EN
  assign w_bypass = w_empty && (r_state == IQ_WAIT) && valid_from_mem && !jump_from_rob;
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_latch_addr   = 1'b0;
    w_push         = 1'b0;
    case (r_state)
      IQ_IDLE: begin
        if (!jump_from_rob && !w_full) begin
          w_state_nxt  = IQ_WAIT;
          w_latch_addr = 1'b1;
        end
      end
      IQ_WAIT: begin
        if (jump_from_rob) begin
          w_state_nxt = valid_from_mem ? IQ_IDLE : IQ_DROP;
        end else if (valid_from_mem) begin
          w_state_nxt    = IQ_IDLE;
          // A bypassed word popped in the same cycle never enters storage.
          w_push         = !(w_bypass && pop_from_dc);
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
      end
      IQ_DROP: begin
        if (valid_from_mem) w_state_nxt = IQ_IDLE;
      end
      default: w_state_nxt = IQ_IDLE;
    endcase
    if (jump_from_rob) w_fetch_pc_nxt = target_pc_from_rob;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IQ_IDLE;
      r_fetch_pc <= ResetPc;
      r_addr     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      if (w_latch_addr) r_addr <= r_fetch_pc;
    end
  end

  iq_fifo #(
    .DepthLog (QueueDepthLog)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (pop_from_dc),
    .i_flush (jump_from_rob),
    .i_pc    (r_fetch_pc),
    .i_instr (instr_from_mem),
    .o_pc    (w_head_pc),
    .o_instr (w_head_instr),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign req_to_mem     = (r_state == IQ_WAIT);
  assign addr_to_mem    = r_addr;
  assign is_empty_to_dc = w_empty && !w_bypass;
  assign pc_to_dc       = w_bypass ? r_fetch_pc     : (w_empty ? Zero : w_head_pc);
  assign instr_to_dc    = w_bypass ? instr_from_mem : (w_empty ? Zero : w_head_instr);

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: queue-based reference model plus directed literal pins.
module tb_instr_queue;

`ifdef INSTR_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pop, jump, valid;
  logic [31:0] target, instr_in;
  logic        o_req, o_empty;
  logic [31:0] o_addr, o_pc, o_instr;

  always #5 clk = ~clk;

  instr_queue #(
    .QueueDepthLog (4),
    .ResetPc       (32'h0)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pop_from_dc        (pop),
    .jump_from_rob      (jump),
    .target_pc_from_rob (target),
    .instr_from_mem     (instr_in),
    .valid_from_mem     (valid),
    .req_to_mem         (o_req),
    .addr_to_mem        (o_addr),
    .is_empty_to_dc     (o_empty),
    .pc_to_dc           (o_pc),
    .instr_to_dc        (o_instr)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: queue contents, fetch pointer, and the outstanding request's fate.
  ent_t        q[$];
  logic [31:0] m_fpc, m_addr;
  bit          m_out, m_stale;

  // Memory responder.
  bit          mem_busy;
  logic [31:0] mem_addr;
  int          mem_wait;
  int          lat;

  int n_pass, n_total, n_req;
  bit prev_req, byp_probe, byp_hit;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [31:0] i;
    i = a >> 2;
    return {i[11:0], 8'h00, i[4:0], 7'h13};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_fpc = 32'h0; m_addr = 32'h0; m_out = 1'b0; m_stale = 1'b0;
    mem_busy = 1'b0; mem_wait = 0;
  endtask

  task automatic model_update();
    int sz;
    bit live, consume;
    if (rst) begin model_reset(); return; end
    sz   = q.size();
    live = m_out && !m_stale;
    if (jump) begin
      q.delete();
      if (live) begin
        if (valid) m_out = 1'b0; else m_stale = 1'b1;
      end else if (m_stale && valid) begin
        m_out = 1'b0; m_stale = 1'b0;
      end
      m_fpc = target;
    end else begin
      consume = BYP && sz == 0 && live && valid && pop;
      if (pop && sz > 0) void'(q.pop_front());
      if (live && valid) begin
        if (!consume) q.push_back({m_fpc, instr_in});
        m_fpc = m_fpc + 32'd4;
        m_out = 1'b0;
      end else if (m_stale && valid) begin
        m_out = 1'b0; m_stale = 1'b0;
      end else if (!m_out && sz < 16) begin
        m_out = 1'b1; m_addr = m_fpc;
      end
    end
  endtask

  task automatic compare_outputs();
    bit byp;
    logic [31:0] e_pc, e_instr;
    byp = BYP && !rst && q.size() == 0 && m_out && !m_stale && valid && !jump;
    e_pc    = byp ? m_fpc    : (q.size() > 0 ? q[0].pc    : 32'h0);
    e_instr = byp ? instr_in : (q.size() > 0 ? q[0].instr : 32'h0);
    check("req",   {31'b0, o_req},   {31'b0, m_out && !m_stale});
    check("addr",  o_addr,           m_addr);
    check("empty", {31'b0, o_empty}, {31'b0, q.size() == 0 && !byp});
    check("pc",    o_pc,             e_pc);
    check("instr", o_instr,          e_instr);
  endtask

  // One cycle: drive at negedge, compare, update model at posedge, return at next negedge.
  task automatic step(input bit p, input int jmode, input logic [31:0] tgt, input bit pop_on_valid);
    bit vnow;
    if (o_req && !prev_req) n_req++;
    prev_req = o_req;
    if (!rst && !mem_busy && o_req) begin
      mem_busy = 1'b1; mem_addr = o_addr; mem_wait = lat;
    end
    vnow     = !rst && mem_busy && mem_wait <= 1;
    valid    = vnow;
    instr_in = vnow ? word_of(mem_addr) : $urandom;
    jump     = (jmode == 1) || (jmode == 2 && vnow);
    target   = tgt;
    pop      = pop_on_valid ? (p && vnow) : p;
    #1;
    compare_outputs();
    if (byp_probe && vnow && m_out && !m_stale && !jump && q.size() == 0) begin
      if (BYP) begin
        check("byp_instr", o_instr, 32'h00A00513);
        check("byp_empty", {31'b0, o_empty}, 32'h0);
      end else begin
        check("nobyp_empty", {31'b0, o_empty}, 32'h1);
      end
      byp_hit = 1'b1;
    end
    @(posedge clk);
    model_update();
    if (vnow) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    @(negedge clk);
    valid = 1'b0; pop = 1'b0; jump = 1'b0;
  endtask

  initial begin
    int r0;
    n_pass = 0; n_total = 0; n_req = 0; prev_req = 1'b0;
    byp_probe = 1'b0; byp_hit = 1'b0;
    pop = 0; jump = 0; valid = 0; target = 0; instr_in = 0;
    lat = 2;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    step(0, 0, 0, 0);
    check("rst_req",   {31'b0, o_req},   32'h0);
    check("rst_addr",  o_addr,           32'h0);
    check("rst_empty", {31'b0, o_empty}, 32'h1);
    check("rst_pc",    o_pc,             32'h0);
    check("rst_instr", o_instr,          32'h0);
    rst = 1'b0;
    step(0, 0, 0, 0);
    check("first_req", {31'b0, o_req}, 32'h1);

    // Fill with no pops.
    repeat (70) step(0, 0, 0, 0);
    check("full_req",    {31'b0, o_req}, 32'h0);
    check("full_pc",     o_pc,           32'h0);
    check("full_instr",  o_instr,        32'h00000013);
    check("model_size",  q.size(),       16);
    check("model_last",  q[15].pc,       32'h3C);
    check("model_word1", q[1].instr,     32'h00100093);

    // Single pop from full.
    r0 = n_req;
    step(1, 0, 0, 0);
    check("pop_head", o_pc, 32'h4);
    repeat (12) step(0, 0, 0, 0);
    check("one_req",  n_req - r0, 1);
    check("req_addr", o_addr,     32'h40);
    check("refull",   q.size(),   16);

    // Continuous pop at 1-cycle memory latency.
    lat = 1;
    repeat (80) step(1, 0, 0, 0);

    // Redirect while waiting; stale word arrives later.
    lat = 4;
    for (int i = 0; i < 20 && !(m_out && !m_stale); i++) step(1, 0, 0, 0);
    step(0, 1, 32'h1000, 0);
    check("jmp_empty", {31'b0, o_empty}, 32'h1);
    for (int i = 0; i < 30 && !o_req; i++) step(0, 0, 0, 0);
    check("jmp_req",  {31'b0, o_req}, 32'h1);
    check("jmp_addr", o_addr,         32'h1000);
    for (int i = 0; i < 30 && o_empty; i++) step(0, 0, 0, 0);
    check("jmp_pc",    o_pc,    32'h1000);
    check("jmp_instr", o_instr, word_of(32'h1000));

    // Redirect coinciding with valid and pop.
    lat = 2;
    for (int i = 0; i < 30 && m_fpc != 32'h2000; i++) step(1, 2, 32'h2000, 1);
    check("jv_empty", {31'b0, o_empty}, 32'h1);
    for (int i = 0; i < 30 && !o_req; i++) step(0, 0, 0, 0);
    check("jv_addr", o_addr, 32'h2000);

    // Empty queue, valid and pop together at pc 0x28.
    step(0, 1, 32'h28, 0);
    byp_probe = 1'b1;
    for (int i = 0; i < 30 && !byp_hit; i++) step(1, 0, 0, 1);
    byp_probe = 1'b0;
    check("byp_seen", {31'b0, byp_hit}, 32'h1);
    if (BYP) begin
      check("byp_after_empty", {31'b0, o_empty}, 32'h1);
    end else begin
      check("nobyp_after_instr", o_instr, 32'h00A00513);
      check("nobyp_after_pc",    o_pc,    32'h28);
    end

    // Randomized traffic with redirects and one mid-request reset.
    for (int c = 0; c < 2500; c++) begin
      lat = $urandom_range(1, 4);
      if (c == 1200) begin
        for (int i = 0; i < 20 && !(m_out && !m_stale); i++) step(0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
      end
      step((c < 1200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0) ? 1 : 0,
           {$urandom_range(0, 32'h3FFF), 2'b00}, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
